div_seq_controller: RTL and testbench
=====================================

# div_seq_controller

Multi-cycle restoring-divider sequencer on the Nios II Avalon-MM bus. Software writes dividend and divisor, issues a start, and the block iterates one quotient bit per cycle. It then latches quotient and remainder, raises done, and optionally raises irq. `quot_out` drives the 8-bit `in_port` of the existing div9-to-software PIO, so software can read the result either there or directly from this block.

## Interface
- WIDTH, 8: operand, quotient and remainder width (2..16).
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  registered read data, zero-extended.
- irq  out  1  equals done AND irq_en.
- quot_out  out  WIDTH  last quotient; connects to the PIO in_port.
- rem_out  out  WIDTH  last remainder.
- busy  out  1  high while a division is in progress.

## Operation
- Write map:
  - addr0: DIVIDEND shadow.
  - addr1: DIVISOR shadow.
  - addr2: CONTROL. bit0 = start (self-clearing pulse, not stored); bit1 = irq_en (stored).
  - addr3: STATUS. Writing 1 to bit1 clears done. Other bits are ignored.
- Read map:
  - addr0: quot_out.
  - addr1: rem_out.
  - addr2: {irq_en, 1'b0}.
  - addr3: {dbz, done, busy} in bits [2:0].
- States are IDLE, LOAD and ITER.
- IDLE:
  - A write to addr2 with bit0=1 is accepted: go to LOAD, assert busy, clear done and dbz.
- LOAD:
  - Copy the shadows into working registers: rem_acc=0, q_sh=dividend, d=divisor; bit counter = WIDTH-1.
  - If divisor==0: quot_out=all ones, rem_out=dividend, dbz=1, done=1, return to IDLE.
  - Otherwise go to ITER.
- ITER (one per cycle):
  - t = {rem_acc, q_sh[MSB]} at WIDTH+1 bits.
  - If t>=d: rem_acc=t-d and shift 1 into q_sh LSB.
  - Else: rem_acc=t[WIDTH-1:0] and shift 0 into q_sh LSB.
  - On counter==0: write quot_out=q_sh result and rem_out=rem_acc; set done=1, busy=0; go to IDLE. Otherwise decrement the counter.
- Boundary rules:
  - Start while busy is ignored: no restart and no status change.
  - Shadow writes while busy only update the shadows; the running division uses the values latched in LOAD.
  - A start write and a done-clear write cannot coincide because they are different addresses. Done-clear while busy has no effect.
  - quot_out and rem_out change only on completion; they hold their previous values during an operation.
- Reset, asynchronous, at any time including mid-operation:
  - State goes to IDLE.
  - busy, done, dbz, irq_en, irq, quot_out, rem_out, readdata, shadows and working registers all go to 0.

## Timing
- readdata is registered with one-cycle read latency; it updates every clock from the address, as in the PIO.
- Start accepted at edge E0 puts LOAD in the cycle after E0. busy is visible from E0 through E(WIDTH+1).
- ITER occupies edges E1..E(WIDTH).
- Result, done and irq are valid after edge E(WIDTH+1); busy falls at the same edge. For WIDTH=8 this is 9 cycles after the start write.
- Divide-by-zero completes after E1: busy lasts one cycle.
- A new start is accepted on the cycle immediately after done rises.

## Test plan
- 100 / 9: write 100, 9, start. Expect busy for 9 cycles, then quot_out=11, rem_out=1, STATUS=3'b010, PIO in_port=0x0B.
- 255 / 1, then 7 / 9: expect 255/0, then 0/7. Done clears on the second start. quot_out holds 255 until the second completion.
- 42 / 0: expect after 2 cycles quot_out=0xFF, rem_out=42, STATUS=3'b110, no ITER cycles.
- irq_en=1 with 200 / 13: expect irq rises with done, q=15, r=5. A write of 0x2 to STATUS drops irq next cycle.
- Start during busy, plus a DIVISOR write during busy: the running 100/9 is still 11/1. A subsequent start uses the new divisor.
- Assert reset_n mid-ITER: all outputs 0 immediately. After release, 100/9 completes normally.

Source files
------------

// File: rtl/div_seq_controller.sv
// Avalon-MM restoring-divider sequencer: one quotient bit per cycle, results latched
// on completion and mirrored to the div9 PIO in_port through o_quot_out.
module div_seq_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       i_address,
  input  logic             i_chipselect,
  input  logic             i_write_n,
  input  logic [31:0]      i_writedata,
  output logic [31:0]      o_readdata,
  output logic             o_irq,
  output logic [WIDTH-1:0] o_quot_out,
  output logic [WIDTH-1:0] o_rem_out,
  output logic             o_busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StIter} state_e;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_dividend, r_divisor;
  logic [WIDTH-1:0]  r_rem_acc, r_q_sh, r_d;
  logic [WIDTH-1:0]  r_quot, r_rem;
  logic [CntW-1:0]   r_cnt;
  logic              r_irq_en, r_done, r_dbz;
  logic [31:0]       r_readdata;

  logic              w_wr, w_start, w_clr_done, w_load, w_iter, w_last, w_div_zero;
  logic [WIDTH:0]    w_t, w_diff;
  logic              w_ge;
  logic [WIDTH-1:0]  w_rem_nxt, w_q_nxt;
  logic              w_unused_wdata;

  assign w_wr       = i_chipselect & ~i_write_n;
  assign w_start    = w_wr && (i_address == 2'd2) && i_writedata[0] && (r_state == StIdle);
  assign w_clr_done = w_wr && (i_address == 2'd3) && i_writedata[1] && (r_state == StIdle);
  assign w_load     = (r_state == StLoad);
  assign w_iter     = (r_state == StIter);
  assign w_last     = w_iter && (r_cnt == '0);
  assign w_div_zero = (r_divisor == '0);

  // Restoring step: bring down the next dividend bit, subtract if it fits.
  assign w_t       = {r_rem_acc, r_q_sh[WIDTH-1]};
  assign w_diff    = w_t - {1'b0, r_d};
  assign w_ge      = (w_t >= {1'b0, r_d});
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_nxt   = {r_q_sh[WIDTH-2:0], w_ge};

  assign w_unused_wdata = ^i_writedata[31:WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_nxt = StLoad;
      StLoad:  w_state_nxt = w_div_zero ? StIdle : StIter;
      StIter:  if (r_cnt == '0) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_irq_en   <= 1'b0;
    end else if (w_wr) begin
      unique case (i_address)
        2'd0:    r_dividend <= i_writedata[WIDTH-1:0];
        2'd1:    r_divisor  <= i_writedata[WIDTH-1:0];
        2'd2:    r_irq_en   <= i_writedata[1];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (w_start) begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (w_clr_done) begin
      r_done <= 1'b0;
    end else if (w_load && w_div_zero) begin
      r_done <= 1'b1;
      r_dbz  <= 1'b1;
    end else if (w_last) begin
      r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem_acc <= '0;
      r_q_sh    <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
    end else if (w_load) begin
      r_rem_acc <= '0;
      r_q_sh    <= r_dividend;
      r_d       <= r_divisor;
      r_cnt     <= CntW'(WIDTH - 1);
      if (w_div_zero) begin
        r_quot <= '1;
        r_rem  <= r_dividend;
      end
    end else if (w_iter) begin
      r_rem_acc <= w_rem_nxt;
      r_q_sh    <= w_q_nxt;
      r_cnt     <= r_cnt - CntW'(1);
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_rem  <= w_rem_nxt;
      end
    end
  end

  // Read data follows the address every clock, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      unique case (i_address)
        2'd0:    r_readdata <= 32'(r_quot);
        2'd1:    r_readdata <= 32'(r_rem);
        2'd2:    r_readdata <= {30'd0, r_irq_en, 1'b0};
        default: r_readdata <= {29'd0, r_dbz, r_done, (r_state != StIdle)};
      endcase
    end
  end

  assign o_readdata = r_readdata;
  assign o_quot_out = r_quot;
  assign o_rem_out  = r_rem;
  assign o_busy     = (r_state != StIdle);
  assign o_irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_div_seq_controller.sv
// Randomised bench for div_seq_controller: a cycle-level behavioural model built on
// integer / and % is compared every cycle, plus directed literal checks.
module tb_div_seq_controller;
  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd3;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq, busy;
  logic [W-1:0]  quot_out, rem_out;

  int checks = 0;
  int passes = 0;

  div_seq_controller #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_address    (address),
    .i_chipselect (chipselect),
    .i_write_n    (write_n),
    .i_writedata  (writedata),
    .o_readdata   (readdata),
    .o_irq        (irq),
    .o_quot_out   (quot_out),
    .o_rem_out    (rem_out),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: remembers pending work and produces the result with / and %.
  logic [W-1:0] m_dividend, m_divisor, m_quot, m_rem, m_res_q, m_res_r, m_n, m_d;
  logic         m_irq_en, m_done, m_dbz, m_busy, m_loaded;
  logic [31:0]  m_rd;
  int           m_iters_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dividend = '0; m_divisor = '0; m_quot = '0; m_rem = '0;
      m_irq_en = 0; m_done = 0; m_dbz = 0; m_busy = 0; m_loaded = 0;
      m_rd = '0; m_iters_left = 0; m_res_q = '0; m_res_r = '0;
    end else begin
      logic wr;
      wr = chipselect && !write_n;
      case (address)
        2'd0:    m_rd = 32'(m_quot);
        2'd1:    m_rd = 32'(m_rem);
        2'd2:    m_rd = {30'd0, m_irq_en, 1'b0};
        default: m_rd = {29'd0, m_dbz, m_done, m_busy};
      endcase
      if (m_busy) begin
        if (!m_loaded) begin
          m_loaded = 1;
          m_n = m_dividend;
          m_d = m_divisor;
          if (m_d == 0) begin
            m_quot = '1; m_rem = m_n; m_dbz = 1; m_done = 1; m_busy = 0;
          end else begin
            m_res_q = W'(m_n / m_d);
            m_res_r = W'(m_n % m_d);
            m_iters_left = W;
          end
        end else begin
          m_iters_left--;
          if (m_iters_left == 0) begin
            m_quot = m_res_q; m_rem = m_res_r; m_done = 1; m_busy = 0;
          end
        end
      end else if (wr && address == 2'd2 && writedata[0]) begin
        m_busy = 1; m_loaded = 0; m_done = 0; m_dbz = 0;
      end else if (wr && address == 2'd3 && writedata[1]) begin
        m_done = 0;
      end
      if (wr) begin
        case (address)
          2'd0:    m_dividend = writedata[W-1:0];
          2'd1:    m_divisor  = writedata[W-1:0];
          2'd2:    m_irq_en   = writedata[1];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("irq", 32'(irq), 32'(m_done & m_irq_en));
      chk("quot_out", 32'(quot_out), 32'(m_quot));
      chk("rem_out", 32'(rem_out), 32'(m_rem));
      chk("readdata", readdata, m_rd);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3; writedata = '0;
  endtask

  task automatic wait_done(output int n);
    bit ok;
    ok = 0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      n++;
    end
    if (!ok) chk("done_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_div(input int n, input int d, input bit ien, output int cyc);
    wr(2'd0, 32'(n));
    wr(2'd1, 32'(d));
    wr(2'd2, {30'd0, ien, 1'b1});
    wait_done(cyc);
  endtask

  initial begin
    int cyc;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_quot", 32'(quot_out), 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // 100 / 9
    run_div(100, 9, 0, cyc);
    chk("t1_busy_cycles", 32'(cyc), 32'd9);
    chk("t1_quot", 32'(quot_out), 32'd11);
    chk("t1_rem", 32'(rem_out), 32'd1);
    chk("t1_status", readdata, 32'b010);

    // 255 / 1 then 7 / 9
    run_div(255, 1, 0, cyc);
    chk("t2_quot", 32'(quot_out), 32'd255);
    chk("t2_rem", 32'(rem_out), 32'd0);
    wr(2'd0, 32'd7);
    wr(2'd1, 32'd9);
    wr(2'd2, 32'd1);
    @(posedge clk); #1;
    chk("t2_status_running", readdata, 32'b001);
    chk("t2_quot_hold", 32'(quot_out), 32'd255);
    wait_done(cyc);
    chk("t2b_quot", 32'(quot_out), 32'd0);
    chk("t2b_rem", 32'(rem_out), 32'd7);

    // 42 / 0
    run_div(42, 0, 0, cyc);
    chk("t3_busy_cycles", 32'(cyc), 32'd1);
    chk("t3_quot", 32'(quot_out), 32'hFF);
    chk("t3_rem", 32'(rem_out), 32'd42);
    chk("t3_status", readdata, 32'b110);

    // irq path with 200 / 13
    run_div(200, 13, 1, cyc);
    chk("t4_irq", 32'(irq), 32'd1);
    chk("t4_quot", 32'(quot_out), 32'd15);
    chk("t4_rem", 32'(rem_out), 32'd5);
    wr(2'd3, 32'h2);
    chk("t4_irq_clear", 32'(irq), 32'd0);
    wr(2'd2, 32'h0);

    // Start and divisor write while busy
    wr(2'd0, 32'd100);
    wr(2'd1, 32'd9);
    wr(2'd2, 32'd1);
    @(posedge clk); #1;
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd5);
    wait_done(cyc);
    chk("t5_quot", 32'(quot_out), 32'd11);
    chk("t5_rem", 32'(rem_out), 32'd1);
    wr(2'd2, 32'd1);
    wait_done(cyc);
    chk("t5b_quot", 32'(quot_out), 32'd20);
    chk("t5b_rem", 32'(rem_out), 32'd0);

    // Reset mid-ITER
    wr(2'd0, 32'd100);
    wr(2'd1, 32'd9);
    wr(2'd2, 32'd1);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_quot", 32'(quot_out), 32'd0);
    chk("t6_rem", 32'(rem_out), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_readdata", readdata, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run_div(100, 9, 0, cyc);
    chk("t6b_quot", 32'(quot_out), 32'd11);
    chk("t6b_rem", 32'(rem_out), 32'd1);

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 15) == 0) d[W-1:0] = '0;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = d;
      @(posedge clk); #1;
    end
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    wait_done(cyc);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
